// File: rtl/decode_issue.sv
// decode_issue: one-stage RV32I decode/issue with register file and pending-write scoreboard.
// Define WB_BYPASS_EN to forward same-cycle writeback data into operand capture.
module decode_issue #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc_in,
    input  logic            wb_we,
    input  logic [4:0]      wb_wa,
    input  logic [XLEN-1:0] wb_wd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ra,
    output logic [XLEN-1:0] rb,
    output logic [XLEN-1:0] imm,
    output logic [XLEN-1:0] pc_out,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2_shamt,
    output logic [3:0]      alu_op,
    output logic [2:0]      funct3,
    output logic            a_sel,
    output logic            b_sel,
    output logic            jump,
    output logic            branch,
    output logic            reg_we,
    output logic            mem_we,
    output logic            mem_rr,
    output logic            csr_write,
    output logic            illegal
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_ARI_I  = 7'b0010011,
        OP_ARI_R  = 7'b0110011,
        OP_CSR    = 7'b1110011
    } opcode_e;

    logic [XLEN-1:0] regs [NREGS];
    logic [NREGS-1:0] pending, pend_nxt;

    opcode_e         op;
    logic [4:0]      d_rd, d_rs1, d_rs2;
    logic [2:0]      d_f3;
    logic [31:0]     imm32;
    logic [3:0]      d_alu;
    logic            use_rd, use_rs1, use_rs2, known, bad_idx, d_ill;
    logic            d_asel, d_bsel, d_jump, d_branch, d_regwe, d_memwe, d_memrr, d_csr;
    logic            pend1, pend2, byp1, byp2, hz1, hz2, hazard, accept;
    logic [XLEN-1:0] rdata1, rdata2;

    assign op    = opcode_e'(instr[6:0]);
    assign d_rd  = instr[11:7];
    assign d_rs1 = instr[19:15];
    assign d_rs2 = instr[24:20];
    assign d_f3  = instr[14:12];

    always_comb begin
        use_rd   = 1'b0;
        use_rs1  = 1'b0;
        use_rs2  = 1'b0;
        known    = 1'b1;
        d_alu    = '0;
        d_asel   = 1'b0;
        d_bsel   = 1'b1;
        d_jump   = 1'b0;
        d_branch = 1'b0;
        d_memwe  = 1'b0;
        d_memrr  = 1'b0;
        d_csr    = 1'b0;
        imm32    = {{20{instr[31]}}, instr[31:20]};
        case (op)
            OP_LUI: begin
                use_rd = 1'b1;
                imm32  = {instr[31:12], 12'b0};
            end
            OP_AUIPC: begin
                use_rd = 1'b1;
                d_asel = 1'b1;
                imm32  = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                use_rd = 1'b1;
                d_asel = 1'b1;
                d_jump = 1'b1;
                imm32  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OP_JALR: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                d_jump  = 1'b1;
            end
            OP_BRANCH: begin
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                d_jump   = 1'b1;
                d_branch = 1'b1;
                d_bsel   = 1'b0;
                d_alu    = 4'b1000;
                imm32    = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OP_LOAD: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                d_memrr = 1'b1;
            end
            OP_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                d_memwe = 1'b1;
                imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_ARI_I: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                d_alu   = {(d_f3 == 3'b101) & instr[30], d_f3};
            end
            OP_ARI_R: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                d_bsel  = 1'b0;
                d_alu   = {instr[30], d_f3};
            end
            OP_CSR: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                d_csr   = (d_f3 != 3'b000);
            end
            default: known = 1'b0;
        endcase
    end

    assign bad_idx = (use_rd  && int'(d_rd)  >= NREGS) ||
                     (use_rs1 && int'(d_rs1) >= NREGS) ||
                     (use_rs2 && int'(d_rs2) >= NREGS);
    assign d_ill   = !known || bad_idx;
    assign d_regwe = use_rd & !d_ill;

    // Out-of-range indices never hit the scoreboard; they are already illegal.
    assign pend1 = (int'(d_rs1) < NREGS) && pending[d_rs1[AW-1:0]];
    assign pend2 = (int'(d_rs2) < NREGS) && pending[d_rs2[AW-1:0]];
    assign byp1  = wb_we && (wb_wa == d_rs1) && (d_rs1 != 5'd0);
    assign byp2  = wb_we && (wb_wa == d_rs2) && (d_rs2 != 5'd0);

`ifdef WB_BYPASS_EN
    assign hz1    = use_rs1 && pend1 && !byp1;
    assign hz2    = use_rs2 && pend2 && !byp2;
    assign rdata1 = (d_rs1 == 5'd0) ? '0 : byp1 ? wb_wd : regs[d_rs1[AW-1:0]];
    assign rdata2 = (d_rs2 == 5'd0) ? '0 : byp2 ? wb_wd : regs[d_rs2[AW-1:0]];
`else
    assign hz1    = use_rs1 && pend1;
    assign hz2    = use_rs2 && pend2;
    assign rdata1 = (d_rs1 == 5'd0) ? '0 : regs[d_rs1[AW-1:0]];
    assign rdata2 = (d_rs2 == 5'd0) ? '0 : regs[d_rs2[AW-1:0]];
`endif

    assign hazard   = in_valid && (hz1 || hz2);
    assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (wb_we && wb_wa != 5'd0 && int'(wb_wa) < NREGS)
            regs[wb_wa[AW-1:0]] <= wb_wd;
    end

    // Clears first, then the accept-time set, so a same-cycle set wins.
    always_comb begin
        pend_nxt = pending;
        if (wb_we && int'(wb_wa) < NREGS)
            pend_nxt[wb_wa[AW-1:0]] = 1'b0;
        if (flush && out_valid && reg_we)
            pend_nxt[rd[AW-1:0]] = 1'b0;
        if (accept && d_regwe && d_rd != 5'd0)
            pend_nxt[d_rd[AW-1:0]] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            out_valid <= 1'b0;
            ra        <= '0;
            rb        <= '0;
            imm       <= '0;
            pc_out    <= '0;
            rd        <= '0;
            rs1       <= '0;
            rs2_shamt <= '0;
            alu_op    <= '0;
            funct3    <= '0;
            a_sel     <= 1'b0;
            b_sel     <= 1'b0;
            jump      <= 1'b0;
            branch    <= 1'b0;
            reg_we    <= 1'b0;
            mem_we    <= 1'b0;
            mem_rr    <= 1'b0;
            csr_write <= 1'b0;
            illegal   <= 1'b0;
        end else begin
            pending <= pend_nxt;
            if (accept) begin
                out_valid <= 1'b1;
                ra        <= rdata1;
                rb        <= rdata2;
                imm       <= XLEN'($signed(imm32));
                pc_out    <= pc_in;
                rd        <= d_rd;
                rs1       <= d_rs1;
                rs2_shamt <= d_rs2;
                alu_op    <= d_alu;
                funct3    <= d_f3;
                a_sel     <= d_asel;
                b_sel     <= d_bsel;
                jump      <= d_jump;
                branch    <= d_branch;
                reg_we    <= d_regwe;
                mem_we    <= d_memwe & !d_ill;
                mem_rr    <= d_memrr & !d_ill;
                csr_write <= d_csr & !d_ill;
                illegal   <= d_ill;
            end else if (flush || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_decode_issue.sv
// Directed bench for decode_issue: hazards, backpressure, flush, reset, illegal decode.
// A second instance with NREGS=16 covers the out-of-range register index case.
module tb_decode_issue;
    logic        clk = 1'b0;
    logic        rst, in_valid, wb_we, flush, out_ready, in_valid_b;
    logic [31:0] instr, pc_in, wb_wd, instr_b;
    logic [4:0]  wb_wa;

    logic        in_ready, out_valid, a_sel, b_sel, jump, branch, reg_we, mem_we, mem_rr, csr_write, illegal;
    logic [31:0] ra, rb, imm, pc_out;
    logic [4:0]  rd, rs1, rs2_shamt;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;

    logic        in_ready_b, out_valid_b, a_sel_b, b_sel_b, jump_b, branch_b, reg_we_b, mem_we_b, mem_rr_b, csr_write_b, illegal_b;
    logic [31:0] ra_b, rb_b, imm_b, pc_out_b;
    logic [4:0]  rd_b, rs1_b, rs2_shamt_b;
    logic [3:0]  alu_op_b;
    logic [2:0]  funct3_b;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    decode_issue #(.NREGS(32), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .ra(ra), .rb(rb), .imm(imm), .pc_out(pc_out), .rd(rd), .rs1(rs1), .rs2_shamt(rs2_shamt),
        .alu_op(alu_op), .funct3(funct3), .a_sel(a_sel), .b_sel(b_sel), .jump(jump), .branch(branch),
        .reg_we(reg_we), .mem_we(mem_we), .mem_rr(mem_rr), .csr_write(csr_write), .illegal(illegal)
    );

    decode_issue #(.NREGS(16), .XLEN(32)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .instr(instr_b), .pc_in(pc_in),
        .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .flush(flush), .out_valid(out_valid_b), .out_ready(out_ready),
        .ra(ra_b), .rb(rb_b), .imm(imm_b), .pc_out(pc_out_b), .rd(rd_b), .rs1(rs1_b), .rs2_shamt(rs2_shamt_b),
        .alu_op(alu_op_b), .funct3(funct3_b), .a_sel(a_sel_b), .b_sel(b_sel_b), .jump(jump_b), .branch(branch_b),
        .reg_we(reg_we_b), .mem_we(mem_we_b), .mem_rr(mem_rr_b), .csr_write(csr_write_b), .illegal(illegal_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; pc_in = '0; wb_we = 1'b0; wb_wa = '0; wb_wd = '0;
        flush = 1'b0; out_ready = 1'b1; in_valid_b = 1'b0; instr_b = '0;
        tick(); tick();
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_rd", {27'b0, rd}, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_reg_we", {31'b0, reg_we}, 32'd0);
        rst = 1'b0;

        // ADDI x1,x0,5
        in_valid = 1'b1; instr = 32'h00500093; pc_in = 32'h100; #1;
        chk("addi_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("addi_out_valid", {31'b0, out_valid}, 32'd1);
        chk("addi_rd", {27'b0, rd}, 32'd1);
        chk("addi_imm", imm, 32'd5);
        chk("addi_reg_we", {31'b0, reg_we}, 32'd1);
        chk("addi_b_sel", {31'b0, b_sel}, 32'd1);
        chk("addi_pc", pc_out, 32'h100);
        chk("addi_ra_x0", ra, 32'd0);

        // ADD x2,x1,x1 stalls on pending x1
        instr = 32'h00108133; pc_in = 32'h104; #1;
        chk("raw_stall0", {31'b0, in_ready}, 32'd0);
        tick();
        chk("raw_drop_valid", {31'b0, out_valid}, 32'd0);
        chk("raw_stall1", {31'b0, in_ready}, 32'd0);
        wb_we = 1'b1; wb_wa = 5'd1; wb_wd = 32'd5; #1;
`ifdef WB_BYPASS_EN
        chk("raw_wb_ready", {31'b0, in_ready}, 32'd1);
`else
        chk("raw_wb_ready", {31'b0, in_ready}, 32'd0);
        tick();
        wb_we = 1'b0; #1;
        chk("raw_after_wb_ready", {31'b0, in_ready}, 32'd1);
`endif
        tick();
        wb_we = 1'b0;
        chk("raw_out_valid", {31'b0, out_valid}, 32'd1);
        chk("raw_ra", ra, 32'd5);
        chk("raw_rb", rb, 32'd5);
        chk("raw_rd", {27'b0, rd}, 32'd2);
        chk("raw_b_sel", {31'b0, b_sel}, 32'd0);

        // drain and retire x2 = 10
        in_valid = 1'b0; wb_we = 1'b1; wb_wa = 5'd2; wb_wd = 32'd10;
        tick();
        wb_we = 1'b0;

        // LUI x3,0x12345 held under backpressure
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h123451B7; pc_in = 32'h200; #1;
        chk("lui_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        instr = 32'h40208433; pc_in = 32'h204;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_imm", imm, 32'h12345000);
            chk("bp_rd", {27'b0, rd}, 32'd3);
            chk("bp_pc", pc_out, 32'h200);
            tick();
        end
        out_ready = 1'b1; #1;
        chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("sub_rd", {27'b0, rd}, 32'd8);
        chk("sub_alu_op", {28'b0, alu_op}, 32'd8);
        chk("sub_ra", ra, 32'd5);
        chk("sub_rb", rb, 32'd10);
        chk("sub_pc", pc_out, 32'h204);

        // SW x2,8(x1)
        instr = 32'h0020A423; pc_in = 32'h208; #1;
        chk("sw_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("sw_mem_we", {31'b0, mem_we}, 32'd1);
        chk("sw_reg_we", {31'b0, reg_we}, 32'd0);
        chk("sw_imm", imm, 32'd8);
        chk("sw_rb", rb, 32'd10);
        in_valid = 1'b0; wb_we = 1'b1; wb_wa = 5'd3; wb_wd = 32'h33;
        tick();
        wb_wa = 5'd8; wb_wd = 32'h88;
        tick();
        wb_we = 1'b0;

        // flush a held ADDI x4,x0,7
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00700213; pc_in = 32'h300;
        tick();
        in_valid = 1'b0; flush = 1'b1; #1;
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
        in_valid = 1'b1; instr = 32'h00420333; pc_in = 32'h304; out_ready = 1'b1; #1;
        chk("flush_no_stall", {31'b0, in_ready}, 32'd1);
        tick();
        chk("flush_next_valid", {31'b0, out_valid}, 32'd1);
        chk("flush_next_rd", {27'b0, rd}, 32'd6);
        in_valid = 1'b0; wb_we = 1'b1; wb_wa = 5'd6; wb_wd = 32'h6;
        tick();

        // ADDI x5 accepted while writeback clears x5: set wins
        in_valid = 1'b1; instr = 32'h00100293; pc_in = 32'h400; wb_wa = 5'd5; wb_wd = 32'h55; #1;
        chk("setclr_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        wb_we = 1'b0; instr = 32'h000283B3; pc_in = 32'h404; #1;
        chk("setclr_pending", {31'b0, in_ready}, 32'd0);
        in_valid = 1'b0; wb_we = 1'b1; wb_wa = 5'd5; wb_wd = 32'h66;
        tick();
        wb_we = 1'b0; in_valid = 1'b1; #1;
        chk("setclr_cleared", {31'b0, in_ready}, 32'd1);
        tick();
        chk("setclr_ra", ra, 32'h66);
        chk("setclr_rd", {27'b0, rd}, 32'd7);
        in_valid = 1'b0; wb_we = 1'b1; wb_wa = 5'd7; wb_wd = 32'h7;
        tick();
        wb_we = 1'b0;

        // reset during a stall
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093; pc_in = 32'h500;
        tick();
        instr = 32'h00108133; pc_in = 32'h504; #1;
        chk("rststall_stalled", {31'b0, in_ready}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rststall_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rststall_rd", {27'b0, rd}, 32'd0);
        chk("rststall_imm", imm, 32'd0);
        #1;
        chk("rststall_pending_clr", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // unknown opcode on the 32-entry instance, ADD x17 on the 16-entry one
        in_valid = 1'b1; instr = 32'h0000007F; pc_in = 32'h600;
        in_valid_b = 1'b1; instr_b = 32'h002088B3;
        tick();
        chk("unk_illegal", {31'b0, illegal}, 32'd1);
        chk("unk_reg_we", {31'b0, reg_we}, 32'd0);
        chk("unk_out_valid", {31'b0, out_valid}, 32'd1);
        chk("n16_illegal", {31'b0, illegal_b}, 32'd1);
        chk("n16_reg_we", {31'b0, reg_we_b}, 32'd0);
        chk("n16_out_valid", {31'b0, out_valid_b}, 32'd1);
        instr_b = 32'h00108133; #1;
        chk("n16_pending_unchanged", {31'b0, in_ready_b}, 32'd1);
        in_valid_b = 1'b0;

        // JAL x1,16
        instr = 32'h010000EF; pc_in = 32'h700;
        tick();
        in_valid = 1'b0;
        chk("jal_jump", {31'b0, jump}, 32'd1);
        chk("jal_branch", {31'b0, branch}, 32'd0);
        chk("jal_a_sel", {31'b0, a_sel}, 32'd1);
        chk("jal_imm", imm, 32'd16);
        chk("jal_reg_we", {31'b0, reg_we}, 32'd1);
        chk("jal_illegal", {31'b0, illegal}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
